spi_master_slave: RTL and testbench

Single-clock SPI master plus one SPI slave endpoint, both clocked by `clk`. The master generates `sclk` and the active-transfer flag `check1`, drives one of three chip selects, and runs one full-duplex 8-bit exchange per arming. The slave shifts on the same `sclk` edges, qualified by `check1` and its own `s_cs`. The block is the SPI building block that bridges a byte register to an external SPI bus. Its slave half also serves as a loop-back endpoint.

---
 rtl/spi_master_slave.sv | 124 ++++++++++++
 tb/tb_spi_master_slave.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_slave.sv
// SPI master (sclk, chip selects, 8-bit MSB-first full-duplex frame) plus one
// SPI slave endpoint shifting on the master's sample edges, all on one clock.
module spi_master_slave (
  input  logic       clk,
  input  logic       reset,
  input  logic       CPOL,
  input  logic       CPHA,
  input  logic [1:0] select,
  input  logic       m_load,
  input  logic [7:0] initialize_data,
  input  logic       m_miso,
  output logic [7:0] master_data,
  output logic       m_mosi,
  output logic       sclk,
  output logic       cs1,
  output logic       cs2,
  output logic       cs3,
  output logic       check1,
  input  logic       s_load,
  input  logic [7:0] init_data,
  input  logic       s_cs,
  input  logic       s_mosi,
  output logic [7:0] slave_data,
  output logic       s_miso,
  output logic [1:0] o_dbg_state
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] XFER = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0] r_state;
  logic [4:0] r_cnt;
  logic       r_sclk;
  logic       r_check1;
  logic       r_cs1;
  logic       r_cs2;
  logic       r_cs3;
  logic [7:0] r_master_data;
  logic [7:0] r_slave_data;
  logic       w_sample;

  // r_cnt holds the number of sclk edges already produced; the edge about to
  // happen is r_cnt+1, so odd edges are reached from even counts.
  assign w_sample = (r_state == XFER) && (r_cnt != 5'd16) && (r_cnt[0] == CPHA);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_cnt    <= 5'd0;
      r_sclk   <= 1'b0;
      r_check1 <= 1'b0;
      r_cs1    <= 1'b1;
      r_cs2    <= 1'b1;
      r_cs3    <= 1'b1;
    end else if (m_load) begin
      r_state  <= IDLE;
      r_cnt    <= 5'd0;
      r_check1 <= 1'b0;
      r_cs1    <= 1'b1;
      r_cs2    <= 1'b1;
      r_cs3    <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          r_state  <= XFER;
          r_cnt    <= 5'd0;
          r_sclk   <= CPOL;
          r_check1 <= 1'b1;
          r_cs1    <= (select != 2'b00);
          r_cs2    <= (select != 2'b01);
          r_cs3    <= (select != 2'b10);
        end
        XFER: begin
          if (r_cnt == 5'd16) begin
            r_state  <= DONE;
            r_check1 <= 1'b0;
            r_cs1    <= 1'b1;
            r_cs2    <= 1'b1;
            r_cs3    <= 1'b1;
          end else begin
            r_cnt  <= r_cnt + 5'd1;
            r_sclk <= ~r_sclk;
          end
        end
        DONE: begin
          r_state <= DONE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Shift registers are deliberately not reset: only the load strobes write them.
  always_ff @(posedge clk) begin
    if (m_load) begin
      r_master_data <= initialize_data;
    end else if (w_sample) begin
      r_master_data <= {r_master_data[6:0], m_miso};
    end
  end

  always_ff @(posedge clk) begin
    if (s_load) begin
      r_slave_data <= init_data;
    end else if (w_sample && !s_cs && r_check1) begin
      r_slave_data <= {r_slave_data[6:0], s_mosi};
    end
  end

  assign sclk        = (r_state == XFER) ? r_sclk : CPOL;
  assign m_mosi      = r_check1 & r_master_data[7];
  assign s_miso      = r_slave_data[7];
  assign master_data = r_master_data;
  assign slave_data  = r_slave_data;
  assign check1      = r_check1;
  assign cs1         = r_cs1;
  assign cs2         = r_cs2;
  assign cs3         = r_cs3;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_spi_master_slave.sv
// Directed bench for spi_master_slave: SPI modes, select decode, loop-back,
// slave chip-select gating and mid-frame reset abort.
module tb_spi_master_slave;

  logic       clk = 1'b0;
  logic       reset;
  logic       CPOL;
  logic       CPHA;
  logic [1:0] select;
  logic       m_load;
  logic [7:0] initialize_data;
  logic       tb_m_miso;
  logic       m_miso;
  logic [7:0] master_data;
  logic       m_mosi;
  logic       sclk;
  logic       cs1;
  logic       cs2;
  logic       cs3;
  logic       check1;
  logic       s_load;
  logic [7:0] init_data;
  logic       s_cs;
  logic       tb_s_mosi;
  logic       s_mosi;
  logic [7:0] slave_data;
  logic       s_miso;
  logic [1:0] dbg_state;
  logic       loopback;

  int n_tests = 0;
  int n_fail  = 0;

  assign m_miso = loopback ? s_miso : tb_m_miso;
  assign s_mosi = loopback ? m_mosi : tb_s_mosi;

  always #5 clk = ~clk;

  spi_master_slave dut (
    .clk             (clk),
    .reset           (reset),
    .CPOL            (CPOL),
    .CPHA            (CPHA),
    .select          (select),
    .m_load          (m_load),
    .initialize_data (initialize_data),
    .m_miso          (m_miso),
    .master_data     (master_data),
    .m_mosi          (m_mosi),
    .sclk            (sclk),
    .cs1             (cs1),
    .cs2             (cs2),
    .cs3             (cs3),
    .check1          (check1),
    .s_load          (s_load),
    .init_data       (init_data),
    .s_cs            (s_cs),
    .s_mosi          (s_mosi),
    .slave_data      (slave_data),
    .s_miso          (s_miso),
    .o_dbg_state     (dbg_state)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Loads both shift registers while reset is high, then releases reset at a
  // negedge so the frame starts on the next rising edge.
  task automatic start_frame(input logic cpol, input logic cpha, input logic [1:0] sel,
                             input logic [7:0] m_init, input logic [7:0] s_init);
    @(negedge clk);
    reset           = 1'b1;
    CPOL            = cpol;
    CPHA            = cpha;
    select          = sel;
    m_load          = 1'b1;
    initialize_data = m_init;
    s_load          = 1'b1;
    init_data       = s_init;
    @(negedge clk);
    check("pre_sclk_idle", 32'(sclk), 32'(cpol));
    check("pre_check1", 32'(check1), 32'd0);
    check("pre_cs", 32'({cs1, cs2, cs3}), 32'd7);
    m_load = 1'b0;
    s_load = 1'b0;
    reset  = 1'b0;
  endtask

  task automatic measure_frame(input logic cpol, input logic [1:0] sel);
    int   rises;
    int   c1_cyc;
    int   l1;
    int   l2;
    int   l3;
    int   stray;
    logic prev;
    rises = 0; c1_cyc = 0; l1 = 0; l2 = 0; l3 = 0; stray = 0;
    prev  = sclk;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (sclk && !prev) rises++;
      prev = sclk;
      if (check1) c1_cyc++;
      if (!cs1) l1++;
      if (!cs2) l2++;
      if (!cs3) l3++;
      if (!check1 && !(cs1 && cs2 && cs3)) stray++;
    end
    check("sclk_rises", 32'(rises), 32'd8);
    check("check1_cycles", 32'(c1_cyc), 32'd17);
    check("cs1_low_cycles", 32'(l1), (sel == 2'b00) ? 32'd17 : 32'd0);
    check("cs2_low_cycles", 32'(l2), (sel == 2'b01) ? 32'd17 : 32'd0);
    check("cs3_low_cycles", 32'(l3), (sel == 2'b10) ? 32'd17 : 32'd0);
    check("cs_outside_xfer", 32'(stray), 32'd0);
    check("post_sclk_idle", 32'(sclk), 32'(cpol));
    check("post_check1", 32'(check1), 32'd0);
    check("post_state_done", 32'(dbg_state), 32'd2);
  endtask

  initial begin
    reset = 1'b1; CPOL = 1'b0; CPHA = 1'b0; select = 2'b00;
    m_load = 1'b0; initialize_data = 8'h00; tb_m_miso = 1'b0;
    s_load = 1'b0; init_data = 8'h00; s_cs = 1'b0; tb_s_mosi = 1'b0;
    loopback = 1'b0;

    @(negedge clk);
    check("rst_state", 32'(dbg_state), 32'd0);
    check("rst_check1", 32'(check1), 32'd0);
    check("rst_cs", 32'({cs1, cs2, cs3}), 32'd7);
    check("rst_sclk", 32'(sclk), 32'd0);
    check("rst_mosi", 32'(m_mosi), 32'd0);

    // Four modes, each with a different select; slave FF shifts in zeros.
    start_frame(1'b0, 1'b0, 2'b00, 8'h81, 8'hFF);
    measure_frame(1'b0, 2'b00);
    check("m0_slave", 32'(slave_data), 32'h00);
    check("m0_master", 32'(master_data), 32'h00);

    start_frame(1'b0, 1'b1, 2'b01, 8'h81, 8'hFF);
    measure_frame(1'b0, 2'b01);
    check("m1_slave", 32'(slave_data), 32'h00);

    start_frame(1'b1, 1'b1, 2'b10, 8'h81, 8'hFF);
    measure_frame(1'b1, 2'b10);
    check("m3_slave", 32'(slave_data), 32'h00);

    start_frame(1'b1, 1'b0, 2'b11, 8'h81, 8'hFF);
    measure_frame(1'b1, 2'b11);
    check("m2_slave", 32'(slave_data), 32'h00);

    // Loop-back exchange in mode 1.
    loopback = 1'b1;
    start_frame(1'b0, 1'b1, 2'b00, 8'hA5, 8'h3C);
    measure_frame(1'b0, 2'b00);
    check("lb_master", 32'(master_data), 32'h3C);
    check("lb_slave", 32'(slave_data), 32'hA5);
    loopback = 1'b0;

    // Slave deselected: its register must not move; master shifts in ones.
    s_cs      = 1'b1;
    tb_s_mosi = 1'b1;
    tb_m_miso = 1'b1;
    start_frame(1'b0, 1'b0, 2'b00, 8'h00, 8'h5A);
    measure_frame(1'b0, 2'b00);
    check("gate_slave", 32'(slave_data), 32'h5A);
    check("gate_master", 32'(master_data), 32'hFF);
    check("gate_mosi_idle", 32'(m_mosi), 32'd0);
    check("gate_miso", 32'(s_miso), 32'd0);
    s_cs      = 1'b0;
    tb_s_mosi = 1'b0;
    tb_m_miso = 1'b0;

    // Reset abort at clk 6 of a CPOL=1 mode-0 frame on cs3.
    start_frame(1'b1, 1'b0, 2'b10, 8'h00, 8'hFF);
    repeat (6) @(negedge clk);
    check("abort_mid_sclk", 32'(sclk), 32'd0);
    check("abort_mid_cs3", 32'(cs3), 32'd0);
    reset = 1'b1;
    #1;
    check("abort_check1", 32'(check1), 32'd0);
    check("abort_cs", 32'({cs1, cs2, cs3}), 32'd7);
    check("abort_sclk", 32'(sclk), 32'd1);
    check("abort_state", 32'(dbg_state), 32'd0);
    check("abort_slave_kept", 32'(slave_data), 32'hF8);
    check("abort_miso", 32'(s_miso), 32'd1);
    @(negedge clk);
    check("abort_slave_hold", 32'(slave_data), 32'hF8);
    reset = 1'b0;
    @(negedge clk);
    check("restart_check1", 32'(check1), 32'd1);
    check("restart_cs3", 32'(cs3), 32'd0);
    repeat (18) @(negedge clk);
    check("restart_slave", 32'(slave_data), 32'h00);
    check("restart_done", 32'(dbg_state), 32'd2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
